// File: rtl/serial_adder_accum.sv
// serial_adder_accum: bit-serial LSB-first adder assembling a WIDTH-bit sum and final carry
module serial_adder_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic c, s, c_next, take, last;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  always_comb begin
    s = a_bit ^ b_bit ^ c;
    c_next = (a_bit & b_bit) | (c & (a_bit ^ b_bit));
    take = (state == RUN) && !start && bit_valid;
    last = take && (cnt == LAST);
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = start ? RUN : (last ? DONE : RUN);
      default: state_nxt = start ? RUN : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // start in any state clears the word; it outranks a bit arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= 1'b0;
      cnt <= '0;
      sr <= '0;
      sum <= '0;
      carry_out <= 1'b0;
    end else if (start) begin
      c <= 1'b0;
      cnt <= '0;
      sr <= '0;
    end else if (take) begin
      c <= c_next;
      sr <= {s, sr[WIDTH-1:1]};
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) begin
        sum <= {s, sr[WIDTH-1:1]};
        carry_out <= c_next;
      end
    end
  end
  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder_accum.sv
// tb_serial_adder_accum: directed self-checking bench for the bit-serial adder
module tb_serial_adder_accum;
  logic clk = 1'b0;
  logic rst_n, start, bit_valid, a_bit, b_bit;
  logic busy, done, carry_out;
  logic [7:0] sum;
  int checks = 0;
  int errors = 0;
  serial_adder_accum #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
    .sum(sum), .carry_out(carry_out)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_start(input string tag);
    start = 1'b1;
    bit_valid = 1'b0;
    step();
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);
    chk({tag, " done after start"}, done, 0);
  endtask
  // stall[i] inserts one bit_valid=0 cycle (with junk operand bits) before bit i
  task automatic word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] stall,
                      input logic [7:0] es, input logic ec, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (stall[i]) begin
        bit_valid = 1'b0;
        a_bit = 1'b1;
        b_bit = 1'b1;
        step();
        chk({tag, " stall busy"}, busy, 1);
        chk({tag, " stall done"}, done, 0);
      end
      bit_valid = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      step();
      chk($sformatf("%s done after bit %0d", tag, i), done, (i == 7));
    end
    bit_valid = 1'b0;
    chk({tag, " sum"}, sum, es);
    chk({tag, " carry_out"}, carry_out, ec);
    chk({tag, " busy falls"}, busy, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    a_bit = 1'b0;
    b_bit = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset carry", carry_out, 0);
    // bits offered in IDLE must not be consumed
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b1;
    step();
    chk("idle ignores bits", busy, 0);
    do_start("w1");
    word(8'h5A, 8'h3C, 8'h00, 8'h96, 1'b0, "5A+3C");
    step();
    chk("idle after done", done, 0);
    chk("idle busy", busy, 0);
    do_start("w2");
    word(8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, "FF+01");
    step();
    do_start("w3");
    word(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "00+00");
    step();
    do_start("w4");
    word(8'h5A, 8'h3C, 8'b0011_0100, 8'h96, 1'b0, "stalled 5A+3C");
    step();
    // abort after three bits; start and bit_valid together discard that bit
    do_start("w5");
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      a_bit = 1'b1;
      b_bit = 1'b0;
      step();
    end
    chk("abort sum held", sum, 8'h96);
    chk("abort no done", done, 0);
    start = 1'b1;
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b1;
    step();
    start = 1'b0;
    chk("abort stays busy", busy, 1);
    chk("abort sum still held", sum, 8'h96);
    word(8'h12, 8'h34, 8'h00, 8'h46, 1'b0, "12+34");
    step();
    chk("single done pulse", done, 0);
    // asynchronous reset mid-word
    do_start("w6");
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      a_bit = i[0];
      b_bit = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst sum", sum, 0);
    chk("async rst carry", carry_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    do_start("w7");
    word(8'h80, 8'h80, 8'h00, 8'h00, 1'b1, "80+80");
    // back-to-back: start held in the DONE cycle
    do_start("b2b");
    word(8'h0F, 8'hF0, 8'h00, 8'hFF, 1'b0, "0F+F0");
    step();
    chk("final idle done", done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder_accum.md
# serial_adder_accum

Bit-serial adder stage that consumes one operand bit pair per cycle, LSB first, and assembles a WIDTH-bit sum plus final carry. It is the multi-bit, registered successor to the team's combinational one-bit sum/carry cell. It sits directly behind the dedicated input pins of the tile: ui_in bits drive the serial operands and the handshake, and uo_out presents the result. A carry flop closes the loop between bit slices, so a full word costs WIDTH cycles of logic for one bit of adder.

## Interface

- WIDTH, 8, operand and result width in bits (≥2).

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new word: clear carry, bit counter and shift register.
- bit_valid  input  1  a_bit/b_bit carry a valid operand bit pair this cycle.
- a_bit  input  1  operand A bit, LSB first.
- b_bit  input  1  operand B bit, LSB first.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: sum/carry_out just updated.
- sum  output  WIDTH  last completed sum; holds until next completion.
- carry_out  output  1  final carry of last completed word.

## Operation

- States: IDLE, RUN, DONE. Internal registers: carry c, counter cnt (0..WIDTH-1), shift register sr[WIDTH-1:0].
- Per-bit arithmetic: s = a_bit ^ b_bit ^ c; c_next = (a_bit & b_bit) | (c & (a_bit ^ b_bit)).
- Shift: sr <= {s, sr[WIDTH-1:1]}. After WIDTH bits, bit i of the sum is in sr[i].
- IDLE:
  - start=1 → RUN, with c=0, cnt=0, sr=0.
  - bit_valid is ignored in IDLE, including in the start cycle.
- RUN:
  - bit_valid=1 consumes one pair, updates c and sr, and increments cnt.
  - bit_valid=0 stalls; no register changes.
  - Last bit (bit_valid=1 and cnt=WIDTH-1): sum <= {s, sr[WIDTH-1:1]}, carry_out <= c_next, cnt wraps to 0, next state DONE.
  - start=1 in RUN aborts the current word: c=0, cnt=0, sr=0, stay in RUN. start takes priority over bit_valid; that cycle's bit is discarded.
- DONE: lasts one cycle.
  - start=1 → RUN (cleared as above), giving back-to-back words.
  - Otherwise → IDLE.
  - bit_valid is ignored.
- sum and carry_out change only on a last-bit edge or on reset. Aborted words never touch them.
- busy = (state==RUN); done = (state==DONE). Both are decoded from registered state.
- Reset (any time, including mid-word): state=IDLE, c=0, cnt=0, sr=0, sum=0, carry_out=0. Hence busy=0 and done=0.
- Overflow beyond WIDTH is reported only through carry_out. No wider result is kept.

## Timing

- Outputs out of reset: busy=0, done=0, sum=0, carry_out=0.
- start sampled at edge 0 → busy=1 from cycle 1. First bit is accepted at edge 1 at the earliest.
- With bit_valid held high: bits are consumed on edges 1..WIDTH. done=1 and the new sum/carry_out are visible in cycle WIDTH+1, which is 1 cycle after the last bit.
- Each cycle of bit_valid=0 during RUN delays done by exactly one cycle.
- Back-to-back: start asserted in the DONE cycle → busy=1 in the following cycle, with no idle gap.
- rst_n deassertion is not synchronised here. The top-level wrapper provides the synchronised release.

## Test plan

- WIDTH=8, start, then 8 contiguous bits of A=0x5A, B=0x3C → done pulse in cycle 9 after start, sum=0x96, carry_out=0, busy falls with done.
- A=0xFF, B=0x01 → sum=0x00, carry_out=1. Then A=0x00, B=0x00 → sum=0x00, carry_out=0, confirming carry is cleared by start.
- A=0x5A, B=0x3C with bit_valid low for 3 cycles scattered mid-word → sum=0x96, done delayed by exactly 3 cycles, no extra bits consumed.
- After 3 bits of an arbitrary word, assert start, then send A=0x12, B=0x34 → sum=0x46, carry_out=0, exactly one done pulse. sum stays at its previous value until then.
- rst_n low for one cycle after 4 bits → busy=0, done=0, sum=0, carry_out=0 immediately. A following full word A=0x80, B=0x80 → sum=0x00, carry_out=1.
- start held high in the DONE cycle, then A=0x0F, B=0xF0 → busy=1 in the next cycle with no IDLE cycle, second done gives sum=0xFF, carry_out=0.
